branch_cond_unit: RTL and testbench

- Branch-resolution helper for the ID stage of the pipelined RISC core.
- Holds the architectural condition-code flags N, Z, C and V.
- Evaluates an instruction's 4-bit condition field against those flags and decides taken branch vs. NOP.
- Produces the sign-extended, word-scaled branch offset and the branch target address.
- Merges the functions of Cond_Is_Asserted, Condition_Handler and SExtender behind one clocked flag register.

---
 rtl/branch_cond_unit.sv | 106 ++++++++++
 tb/tb_branch_cond_unit.sv | 226 ++++++++++++++++++++++
 2 files changed

// File: rtl/branch_cond_unit.sv
// branch_cond_unit: ID-stage branch resolution helper.
// Holds the NZCV flag register, evaluates the instruction condition field,
// and produces the sign-extended word offset and the branch target.
// Optional macro CC_BYPASS_EN forwards cc_in into condition evaluation
// while s_en is high; without it evaluation always uses the registered flags.
module branch_cond_unit #(
    parameter bit NV_ASSERTS = 1'b0
) (
    input  logic        clk,
    input  logic        reset_n,
    input  logic [31:0] instr,
    input  logic [3:0]  cc_in,
    input  logic        s_en,
    input  logic [31:0] pc_in,
    output logic [3:0]  cc_out,
    output logic        asserted,
    output logic        b_instr,
    output logic        link,
    output logic        choose_ta_r_nop,
    output logic [31:0] sext4_out,
    output logic [31:0] branch_target
);

    localparam int unsigned W_DATA = 32;
    localparam int unsigned W_CC   = 4;
    localparam int unsigned W_OFF  = 24;
    localparam int unsigned W_EXT  = W_DATA - W_OFF - 2;

    logic [W_CC-1:0] cc_q;
    logic [W_CC-1:0] cc_d;
    logic [W_CC-1:0] flags_c;
    logic            n_f;
    logic            z_f;
    logic            c_f;
    logic            v_f;

    // Next flag value: capture ALU flags when the S bit is set, else hold
    always_comb begin
        cc_d = cc_q;
        if (s_en) begin
            cc_d = cc_in;
        end
    end

    // Flag register with asynchronous clear
    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            cc_q <= '0;
        end else begin
            cc_q <= cc_d;
        end
    end

    assign cc_out = cc_q;

    // Flags used for evaluation, optionally forwarding the same-cycle result
    always_comb begin
`ifdef CC_BYPASS_EN
        flags_c = s_en ? cc_in : cc_q;
`else
        flags_c = cc_q;
`endif
    end

    assign n_f = flags_c[3];
    assign z_f = flags_c[2];
    assign c_f = flags_c[1];
    assign v_f = flags_c[0];

    // Condition field decode; every code yields a defined value
    always_comb begin
        asserted = 1'b0;
        case (instr[31:28])
            4'b0000: asserted = z_f;
            4'b0001: asserted = !z_f;
            4'b0010: asserted = c_f;
            4'b0011: asserted = !c_f;
            4'b0100: asserted = n_f;
            4'b0101: asserted = !n_f;
            4'b0110: asserted = v_f;
            4'b0111: asserted = !v_f;
            4'b1000: asserted = c_f & !z_f;
            4'b1001: asserted = !c_f | z_f;
            4'b1010: asserted = (n_f == v_f);
            4'b1011: asserted = (n_f != v_f);
            4'b1100: asserted = !z_f & (n_f == v_f);
            4'b1101: asserted = z_f | (n_f != v_f);
            4'b1110: asserted = 1'b1;
            4'b1111: asserted = NV_ASSERTS;
        endcase
    end

    // Branch class decode and taken/NOP selection
    always_comb begin
        b_instr         = (instr[27:25] == 3'b101);
        link            = b_instr & instr[24];
        choose_ta_r_nop = asserted & b_instr;
    end

    // Word-scaled sign-extended offset and wrapping target add
    always_comb begin
        sext4_out     = {{W_EXT{instr[W_OFF-1]}}, instr[W_OFF-1:0], 2'b00};
        branch_target = W_DATA'(pc_in + sext4_out);
    end

endmodule

// File: tb/tb_branch_cond_unit.sv
// Self-checking bench for branch_cond_unit: directed sequences, a condition
// table sweep, and randomized traffic against an arithmetic reference model.
module tb_branch_cond_unit;

    localparam bit NV = 1'b0;
`ifdef CC_BYPASS_EN
    localparam bit BYPASS = 1'b1;
`else
    localparam bit BYPASS = 1'b0;
`endif

    logic        clk = 1'b0;
    logic        reset_n;
    logic [31:0] instr;
    logic [3:0]  cc_in;
    logic        s_en;
    logic [31:0] pc_in;
    logic [3:0]  cc_out;
    logic        asserted;
    logic        b_instr;
    logic        link;
    logic        choose_ta_r_nop;
    logic [31:0] sext4_out;
    logic [31:0] branch_target;

    int n_cmp = 0;
    int n_bad = 0;
    logic [3:0] m_cc = 4'b0000;

    typedef struct {
        logic [3:0] code;
        logic       exp_asserted;
    } vec_t;

    vec_t tbl[16];

    branch_cond_unit #(.NV_ASSERTS(NV)) dut (
        .clk            (clk),
        .reset_n        (reset_n),
        .instr          (instr),
        .cc_in          (cc_in),
        .s_en           (s_en),
        .pc_in          (pc_in),
        .cc_out         (cc_out),
        .asserted       (asserted),
        .b_instr        (b_instr),
        .link           (link),
        .choose_ta_r_nop(choose_ta_r_nop),
        .sext4_out      (sext4_out),
        .branch_target  (branch_target)
    );

    always #5 clk = ~clk;

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_cmp++;
        if (act !== exp) begin
            n_bad++;
            $display("FAIL %s: got %h expected %h", name, act, exp);
        end
    endtask

    // Reference condition: pairs of codes share a predicate, odd code inverts it
    function automatic bit ref_cond(input logic [3:0] code, input logic [3:0] f);
        bit n, z, c, v, base;
        n = f[3]; z = f[2]; c = f[1]; v = f[0];
        if (code == 4'hF) return NV;
        case (code[3:1])
            3'd0: base = z;
            3'd1: base = c;
            3'd2: base = n;
            3'd3: base = v;
            3'd4: base = c && !z;
            3'd5: base = (n == v);
            3'd6: base = !z && (n == v);
            default: base = 1'b1;
        endcase
        return code[0] ? !base : base;
    endfunction

    // Compare all combinational outputs against the reference model
    task automatic check_comb(input string tag);
        logic [3:0]  f;
        int          off;
        logic [31:0] e_sext;
        logic [31:0] e_tgt;
        bit          e_as, e_b;
        f      = (BYPASS && s_en) ? cc_in : m_cc;
        e_as   = ref_cond(instr[31:28], f);
        e_b    = (instr[27:25] == 3'b101);
        off    = $signed(instr[23:0]);
        off    = off * 4;
        e_sext = 32'(off);
        e_tgt  = 32'(pc_in + e_sext);
        check({tag, ".asserted"}, 32'(asserted), 32'(e_as));
        check({tag, ".b_instr"}, 32'(b_instr), 32'(e_b));
        check({tag, ".link"}, 32'(link), 32'(e_b && instr[24]));
        check({tag, ".choose"}, 32'(choose_ta_r_nop), 32'(e_as && e_b));
        check({tag, ".sext4"}, sext4_out, e_sext);
        check({tag, ".target"}, branch_target, e_tgt);
    endtask

    // Advance one clock edge, update the model flag register, settle
    task automatic tick();
        @(posedge clk);
        if (reset_n && s_en) m_cc = cc_in;
        #1;
    endtask

    initial begin
        tbl[0]  = '{4'h0, 1'b1};  tbl[1]  = '{4'h1, 1'b0};
        tbl[2]  = '{4'h2, 1'b0};  tbl[3]  = '{4'h3, 1'b1};
        tbl[4]  = '{4'h4, 1'b0};  tbl[5]  = '{4'h5, 1'b1};
        tbl[6]  = '{4'h6, 1'b0};  tbl[7]  = '{4'h7, 1'b1};
        tbl[8]  = '{4'h8, 1'b0};  tbl[9]  = '{4'h9, 1'b1};
        tbl[10] = '{4'hA, 1'b1};  tbl[11] = '{4'hB, 1'b0};
        tbl[12] = '{4'hC, 1'b0};  tbl[13] = '{4'hD, 1'b1};
        tbl[14] = '{4'hE, 1'b1};  tbl[15] = '{4'hF, NV};

        reset_n = 1'b0;
        s_en    = 1'b0;
        cc_in   = 4'b0000;
        instr   = 32'h0;
        pc_in   = 32'h0;
        #12;
        check("reset.cc_out", 32'(cc_out), 32'h0);

        // Reset release, then bypass-sensitive decode of an LE branch-with-link
        @(negedge clk);
        reset_n = 1'b1;
        s_en    = 1'b1;
        cc_in   = 4'b0011;
        instr   = 32'hDB000001;
        pc_in   = 32'h00000100;
        #1;
        check("t1.asserted", 32'(asserted), 32'(BYPASS));
        check("t1.b_instr", 32'(b_instr), 32'h1);
        check("t1.link", 32'(link), 32'h1);
        check("t1.choose", 32'(choose_ta_r_nop), 32'(BYPASS));
        check("t1.sext4", sext4_out, 32'h00000004);
        check("t1.target", branch_target, 32'h00000104);
        check_comb("t1");
        tick();
        check("t1.cc_after", 32'(cc_out), 32'h3);
        check("t1.asserted_after", 32'(asserted), 32'h1);

        // Flag capture and hold
        cc_in = 4'b1111;
        tick();
        check("t2.capture", 32'(cc_out), 32'hF);
        s_en  = 1'b0;
        cc_in = 4'b0000;
        tick();
        check("t2.hold", 32'(cc_out), 32'hF);

        // Non-branch instruction with a true condition
        instr = 32'hE0810002;
        #1;
        check("t3.asserted", 32'(asserted), 32'h1);
        check("t3.b_instr", 32'(b_instr), 32'h0);
        check("t3.choose", 32'(choose_ta_r_nop), 32'h0);

        // Negative offset wrapping below zero
        instr = 32'hEAFFFFFE;
        pc_in = 32'h00000004;
        #1;
        check("t4.sext4", sext4_out, 32'hFFFFFFF8);
        check("t4.target", branch_target, 32'hFFFFFFFC);
        check("t4.choose", 32'(choose_ta_r_nop), 32'h1);

        // Condition sweep with registered flags Z=1 only
        s_en  = 1'b1;
        cc_in = 4'b0100;
        tick();
        s_en  = 1'b0;
        cc_in = 4'b1011;
        pc_in = 32'h00001000;
        for (int i = 0; i < 16; i++) begin
            instr = {tbl[i].code, 4'hA, 24'h000010};
            #1;
            check($sformatf("sweep%0d.asserted", i), 32'(asserted), 32'(tbl[i].exp_asserted));
            check($sformatf("sweep%0d.choose", i), 32'(choose_ta_r_nop), 32'(tbl[i].exp_asserted));
            check($sformatf("sweep%0d.target", i), branch_target, 32'h00001040);
        end

        // Randomized traffic against the reference model
        for (int k = 0; k < 400; k++) begin
            s_en  = 1'($urandom_range(0, 1));
            cc_in = 4'($urandom);
            instr = $urandom;
            if ($urandom_range(0, 1) == 1) instr[27:25] = 3'b101;
            pc_in = $urandom;
            #1;
            check_comb($sformatf("rnd%0d", k));
            tick();
            check($sformatf("rnd%0d.cc_out", k), 32'(cc_out), 32'(m_cc));
        end

        // Asynchronous reset between edges; pending capture is lost
        s_en  = 1'b1;
        cc_in = 4'b1010;
        tick();
        s_en = 1'b0;
        check("t6.pre", 32'(cc_out), 32'hA);
        #2;
        reset_n = 1'b0;
        #1;
        check("t6.async_clear", 32'(cc_out), 32'h0);
        s_en  = 1'b1;
        cc_in = 4'b1111;
        tick();
        check("t6.edge_lost", 32'(cc_out), 32'h0);
        m_cc = 4'b0000;
        @(negedge clk);
        s_en    = 1'b0;
        reset_n = 1'b1;
        instr   = 32'h0A000000;
        #1;
        check("t6.eq_after_reset", 32'(asserted), 32'h0);
        check_comb("t6");

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
        $finish;
    end

endmodule
